cd4511_mux: RTL

- Multi-digit successor to the cd4511 BCD-to-7-segment decoder.
- Latches DIGITS BCD nibbles, decodes them with CD4511 semantics (lamp test, blanking, codes 10-15 blank) and drives one shared segment bus.
- Time-multiplexes the digits across per-digit common-terminal selects, with ghost blanking on every digit change and optional leading-zero suppression.
- Sits between the BCD counter/arithmetic logic and the board's multiplexed display.

---
 rtl/cd4511_mux.sv | 73 +++++++
 1 files changed

// File: rtl/cd4511_mux.sv
// cd4511_mux: latches DIGITS BCD nibbles, decodes with CD4511 rules and time-multiplexes them onto one segment bus
module cd4511_mux #(
  parameter int DIGITS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int COMMON_ANODE = 0,
  parameter int TAILS = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   BCD,
  input  logic                  LightTest,
  input  logic                  BLanking,
  input  logic                  LatchEnable,
  input  logic                  ZeroBlank,
  output logic                  COMC,
  output logic [6:0]            SEG,
  output logic [DIGITS-1:0]     AN
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_OFF = COMMON_ANODE != 0 ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF = COMMON_ANODE != 0 ? '0 : '1;
  logic [3:0] dig [DIGITS];
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DIGITS-1:0] lz;
  logic [3:0] cur;
  logic [6:0] raw, glyph;
  logic dark, last;
  assign COMC = COMMON_ANODE == 0;
  assign cur = dig[idx];
  assign last = cnt == CW'(SCAN_DIV - 1);
  // lz[k]: this digit and every more significant one are zero
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = dig[DIGITS-1] == 4'd0;
    for (int k = DIGITS - 2; k >= 0; k--) lz[k] = lz[k+1] & (dig[k] == 4'd0);
  end
  always_comb begin
    raw = 7'h00;
    case (cur)
      4'd0: raw = 7'h3F;
      4'd1: raw = 7'h06;
      4'd2: raw = 7'h5B;
      4'd3: raw = 7'h4F;
      4'd4: raw = 7'h66;
      4'd5: raw = 7'h6D;
      4'd6: raw = TAILS != 0 ? 7'h7D : 7'h7C;
      4'd7: raw = 7'h07;
      4'd8: raw = 7'h7F;
      4'd9: raw = TAILS != 0 ? 7'h6F : 7'h67;
      default: raw = 7'h00;
    endcase
  end
  assign dark = !BLanking || cur > 4'd9 || (ZeroBlank && idx != '0 && lz[idx]);
  assign glyph = !LightTest ? 7'h7F : dark ? 7'h00 : raw;
  // cnt==0 is the ghost slot: everything off while the select moves to the next digit
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < DIGITS; k++) dig[k] <= '0;
      cnt <= '0;
      idx <= '0;
      SEG <= SEG_OFF;
      AN <= AN_OFF;
    end else begin
      if (!LatchEnable) for (int k = 0; k < DIGITS; k++) dig[k] <= BCD[4*k +: 4];
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      SEG <= cnt == '0 ? SEG_OFF : glyph ^ SEG_OFF;
      AN <= cnt == '0 ? AN_OFF : AN_OFF ^ (DIGITS'(1) << idx);
    end
  end
endmodule
